// File: rtl/hockey_pkg.sv
// Shared definitions for the hockey scoreboard display: segment codes,
// FSM state encoding, TURN encodings and the symbol codes fed to seg7_encode.
package hockey_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_FLASH = 2'd1,
    ST_OVER  = 2'd2
  } state_t;

  localparam logic [1:0] TURN_IDLE = 2'd0;
  localparam logic [1:0] TURN_A    = 2'd1;
  localparam logic [1:0] TURN_B    = 2'd2;

  // Symbol codes: 0-7 are the digits themselves, the rest are letters/marks.
  typedef logic [3:0] sym_t;
  localparam sym_t SYM_A     = 4'd8;
  localparam sym_t SYM_B     = 4'd9;
  localparam sym_t SYM_DASH  = 4'd10;
  localparam sym_t SYM_BLANK = 4'd11;

  // Active-low segment patterns {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] AN_OFF    = 8'hFF;

  function automatic sym_t digit_sym(input logic [2:0] value);
    return {1'b0, value};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Symbol code to active-low seven-segment pattern; unknown codes show blank.
module seg7_encode
  import hockey_pkg::*;
(
  input  logic [3:0] sym,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (sym)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      SYM_A:    seg = SEG_A;
      SYM_B:    seg = SEG_B;
      SYM_DASH: seg = SEG_DASH;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hockey_display.sv
// Eight-digit multiplexed scoreboard with goal flash and game-over screens.
// All outputs are registered from the current scan index and state.
module hockey_display
  import hockey_pkg::*;
#(
  parameter int REFRESH_DIV  = 16,
  parameter int BLINK_DIV    = 64,
  parameter int FLASH_BLINKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] X_COORD,
  input  logic [2:0] Y_COORD,
  input  logic [2:0] SCOREA,
  input  logic [2:0] SCOREB,
  input  logic [1:0] TURN,
  input  logic       GOAL_A,
  input  logic       GOAL_B,
  input  logic       END_GAME,
  output logic [7:0] AN,
  output logic [6:0] SEG,
  output logic       LEDA,
  output logic       LEDB,
  output logic [4:0] LEDX
);

  localparam int RW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HALVES = 2 * FLASH_BLINKS;
  localparam int HW     = (HALVES > 1) ? $clog2(HALVES) : 1;

  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST    = HW'(HALVES - 1);

  state_t          state_reg, state_next;
  logic [RW-1:0]   refresh_cnt_reg;
  logic [2:0]      digit_idx_reg;
  logic [BW-1:0]   blink_cnt_reg, blink_cnt_next;
  logic [HW-1:0]   half_cnt_reg, half_cnt_next;
  logic            phase_reg, phase_next;
  logic            scorer_a_reg, scorer_a_next;
  logic            scorer_b_reg, scorer_b_next;

  logic [7:0]      an_reg, an_next;
  logic [6:0]      seg_reg, seg_next;
  logic            leda_reg, leda_next;
  logic            ledb_reg, ledb_next;
  logic [4:0]      ledx_reg, ledx_next;

  logic            goal;
  logic            blink_last;
  logic            flash_done;
  logic            a_wins, b_wins;
  sym_t            sym;
  sym_t            winner_sym;
  logic [7:0]      an_scan;
  logic [4:0]      ledx_onehot;

  assign goal       = GOAL_A | GOAL_B;
  assign blink_last = (blink_cnt_reg == BLINK_LAST);
  assign flash_done = blink_last && (half_cnt_reg == HALF_LAST);
  assign a_wins     = (SCOREA > SCOREB);
  assign b_wins     = (SCOREB > SCOREA);
  assign winner_sym = a_wins ? SYM_A : (b_wins ? SYM_B : SYM_DASH);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_an_scan
      assign an_scan[gi] = (digit_idx_reg != 3'(gi));
    end
    // Columns 5-7 have no LED, so they leave the indicator dark.
    for (gi = 0; gi < 5; gi++) begin : g_ledx
      assign ledx_onehot[gi] = (X_COORD == 3'(gi));
    end
  endgenerate

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_PLAY;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    if (END_GAME) begin
      state_next = ST_OVER;
    end else begin
      case (state_reg)
        ST_PLAY:  if (goal) state_next = ST_FLASH;
        ST_FLASH: if (!goal && flash_done) state_next = ST_PLAY;
        ST_OVER:  state_next = ST_PLAY;
        default:  state_next = ST_PLAY;
      endcase
    end
  end

  // Flash timing and scorer latch; a goal while flashing restarts the sequence.
  always_comb begin
    blink_cnt_next = '0;
    half_cnt_next  = '0;
    phase_next     = 1'b0;
    scorer_a_next  = 1'b0;
    scorer_b_next  = 1'b0;
    if (state_next == ST_FLASH) begin
      if (goal) begin
        scorer_a_next = GOAL_A | ((state_reg == ST_FLASH) & scorer_a_reg);
        scorer_b_next = GOAL_B | ((state_reg == ST_FLASH) & scorer_b_reg);
      end else begin
        scorer_a_next  = scorer_a_reg;
        scorer_b_next  = scorer_b_reg;
        blink_cnt_next = blink_last ? '0 : blink_cnt_reg + 1'b1;
        half_cnt_next  = blink_last ? half_cnt_reg + 1'b1 : half_cnt_reg;
        phase_next     = blink_last ? ~phase_reg : phase_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_reg <= '0;
      half_cnt_reg  <= '0;
      phase_reg     <= 1'b0;
      scorer_a_reg  <= 1'b0;
      scorer_b_reg  <= 1'b0;
    end else begin
      blink_cnt_reg <= blink_cnt_next;
      half_cnt_reg  <= half_cnt_next;
      phase_reg     <= phase_next;
      scorer_a_reg  <= scorer_a_next;
      scorer_b_reg  <= scorer_b_next;
    end
  end

  // Digit scan runs continuously, independent of the game state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= 3'd0;
    end else if (refresh_cnt_reg == REFRESH_LAST) begin
      refresh_cnt_reg <= '0;
      digit_idx_reg   <= digit_idx_reg + 3'd1;
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
    end
  end

  // ---------------- FSM: output logic ----------------
  always_comb begin
    case (digit_idx_reg)
      3'd7:    sym = (state_reg == ST_OVER) ? winner_sym : SYM_A;
      3'd6:    sym = digit_sym(SCOREA);
      3'd5:    sym = SYM_BLANK;
      3'd4:    sym = SYM_DASH;
      3'd3:    sym = SYM_B;
      3'd2:    sym = digit_sym(SCOREB);
      3'd1:    sym = digit_sym(X_COORD);
      default: sym = digit_sym(Y_COORD);
    endcase

    an_next   = an_scan;
    leda_next = 1'b0;
    ledb_next = 1'b0;
    ledx_next = ledx_onehot;
    case (state_reg)
      ST_PLAY: begin
        leda_next = (TURN == TURN_A);
        ledb_next = (TURN == TURN_B);
      end
      ST_FLASH: begin
        if (!phase_reg) an_next = AN_OFF;
        leda_next = phase_reg & scorer_a_reg;
        ledb_next = phase_reg & scorer_b_reg;
      end
      ST_OVER: begin
        leda_next = a_wins;
        ledb_next = b_wins;
        ledx_next = 5'h1F;
      end
      default: begin
        an_next = AN_OFF;
      end
    endcase
  end

  seg7_encode u_seg7_encode (
    .sym (sym),
    .seg (seg_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_reg   <= AN_OFF;
      seg_reg  <= SEG_BLANK;
      leda_reg <= 1'b0;
      ledb_reg <= 1'b0;
      ledx_reg <= 5'h00;
    end else begin
      an_reg   <= an_next;
      seg_reg  <= seg_next;
      leda_reg <= leda_next;
      ledb_reg <= ledb_next;
      ledx_reg <= ledx_next;
    end
  end

  assign AN   = an_reg;
  assign SEG  = seg_reg;
  assign LEDA = leda_reg;
  assign LEDB = ledb_reg;
  assign LEDX = ledx_reg;

endmodule
